sfifo_gen: RTL and testbench

Parametrised single-clock FIFO; next generation of the team's synchronous FIFO. Adds arbitrary (non-power-of-two) depth, programmable almost-full/almost-empty thresholds, a fill-level output, read-valid qualification and simultaneous read/write at full. It sits between a producer and a consumer in one clock domain as a drop-in buffer. The port names of the original FIFO are kept so existing benches can be reused.

---
 rtl/sfifo_gen_pkg.sv | 26 ++
 rtl/sfifo_gen_mem.sv | 29 ++
 rtl/sfifo_gen.sv | 157 +++++++++++++++
 tb/tb_sfifo_gen.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sfifo_gen_pkg.sv
// Shared constants and helpers for the sfifo_gen synchronous FIFO.
// Holds the level-width and wrapping pointer-increment functions plus default sizing.
package sfifo_gen_pkg;

    localparam int DEF_WIDTH     = 32'sd8;
    localparam int DEF_DEPTH     = 32'sd16;
    localparam int DEF_AF_MARGIN = 32'sd2;
    localparam int DEF_AE_LEVEL  = 32'sd2;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth + 32'sd1);
    endfunction

    // Advance a pointer by one, wrapping at depth-1 so any depth works.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        int unsigned nxt;
        if (ptr >= depth - 32'd1) begin
            nxt = 32'd0;
        end else begin
            nxt = ptr + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sfifo_gen_mem.sv
// DEPTH x WIDTH storage for sfifo_gen: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the top level tracks which entries are valid.
module sfifo_gen_mem
    import sfifo_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = 32'sd4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port: store the accepted word on the rising edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sfifo_gen.sv
// Parametrised single-clock FIFO with arbitrary depth, thresholds, level and rvalid.
// Define SFIFO_GEN_FWFT_EN for first-word-fall-through; default is registered read.
module sfifo_gen
    import sfifo_gen_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - DEF_AF_MARGIN,
    parameter int AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic                        clk,
    input  logic                        res,
    input  logic                        wr_en,
    input  logic [WIDTH-1:0]            wdata,
    input  logic                        rd_en,
    output logic [WIDTH-1:0]            rdata,
    output logic                        rvalid,
    output logic                        empty,
    output logic                        full,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [level_w(DEPTH)-1:0]   level,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int LW = level_w(DEPTH);
    localparam int PW = (DEPTH > 32'sd2) ? $clog2(DEPTH) : 32'sd1;

    if (DEPTH < 32'sd2) begin : g_bad_depth
        $error("sfifo_gen: DEPTH must be at least 2");
    end
    if ((AF_LEVEL < 32'sd1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
        $error("sfifo_gen: AF_LEVEL must lie in 1..DEPTH");
    end
    if ((AE_LEVEL < 32'sd0) || (AE_LEVEL >= DEPTH)) begin : g_bad_ae
        $error("sfifo_gen: AE_LEVEL must lie in 0..DEPTH-1");
    end

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             empty_q, empty_d, full_q, full_d;
    logic             af_q, af_d, ae_q, ae_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             rd_acc_s, wr_acc_s;
    logic [WIDTH-1:0] mem_rdata_s;

    sfifo_gen_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc_s),
        .waddr (wr_ptr_q),
        .wdata (wdata),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata_s)
    );

    // Accept/reject decisions, next pointers, next level and next flags.
    always_comb begin
        rd_acc_s = rd_en && !empty_q;
        // A pop in the same cycle frees the slot, so a full FIFO can still take a write.
        wr_acc_s = wr_en && (!full_q || rd_acc_s);

        case ({wr_acc_s, rd_acc_s})
            2'b10:   level_d = level_q + LW'(32'd1);
            2'b01:   level_d = level_q - LW'(32'd1);
            default: level_d = level_q;
        endcase

        if (wr_acc_s) begin
            wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), 32'(DEPTH)));
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_acc_s) begin
            rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), 32'(DEPTH)));
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        empty_d = (level_d == LW'(32'd0));
        full_d  = (level_d == LW'(DEPTH));
        af_d    = (level_d >= LW'(AF_LEVEL));
        ae_d    = (level_d <= LW'(AE_LEVEL));
        ovf_d   = wr_en && !wr_acc_s;
        unf_d   = rd_en && !rd_acc_s;
    end

    // Pointer, level and flag registers.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

`ifdef SFIFO_GEN_FWFT_EN
    assign rdata  = mem_rdata_s;
    assign rvalid = !empty_q;
`else
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    // Next read-data register value: load on an accepted pop, otherwise hold.
    always_comb begin
        rvalid_d = rd_acc_s;
        if (rd_acc_s) begin
            rdata_d = mem_rdata_s;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Registered read data and its one-cycle valid.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
`endif

    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sfifo_gen.sv
// Directed self-checking bench for sfifo_gen: a DEPTH=16 and a DEPTH=5 instance.
// Works in both the default and SFIFO_GEN_FWFT_EN builds.
module tb_sfifo_gen;

    logic       clk;
    logic       res;

    logic       wr16, rd16;
    logic [7:0] wd16, rdata16;
    logic       rvalid16, empty16, full16, af16, ae16, ovf16, unf16;
    logic [4:0] level16;

    logic       wr5, rd5;
    logic [7:0] wd5, rdata5;
    logic       rvalid5, empty5, full5, af5, ae5, ovf5, unf5;
    logic [2:0] level5;

    int n_chk;
    int n_fail;

    sfifo_gen #(.WIDTH(8), .DEPTH(16)) u_dut16 (
        .clk(clk), .res(res), .wr_en(wr16), .wdata(wd16), .rd_en(rd16),
        .rdata(rdata16), .rvalid(rvalid16), .empty(empty16), .full(full16),
        .almost_full(af16), .almost_empty(ae16), .level(level16),
        .overflow(ovf16), .underflow(unf16)
    );

    sfifo_gen #(.WIDTH(8), .DEPTH(5)) u_dut5 (
        .clk(clk), .res(res), .wr_en(wr5), .wdata(wd5), .rd_en(rd5),
        .rdata(rdata5), .rvalid(rvalid5), .empty(empty5), .full(full5),
        .almost_full(af5), .almost_empty(ae5), .level(level5),
        .overflow(ovf5), .underflow(unf5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push16(input logic [7:0] d);
        wr16 = 1'b1; rd16 = 1'b0; wd16 = d;
        step();
        wr16 = 1'b0;
    endtask

    task automatic pop16(input string tag, input logic [7:0] exp);
        wr16 = 1'b0; rd16 = 1'b1;
`ifdef SFIFO_GEN_FWFT_EN
        check(tag, {24'd0, rdata16}, {24'd0, exp});
        step();
`else
        step();
        check(tag, {24'd0, rdata16}, {24'd0, exp});
        check({tag, "_rvalid"}, {31'd0, rvalid16}, 32'd1);
`endif
        rd16 = 1'b0;
    endtask

    task automatic pop5(input string tag, input logic [7:0] exp);
        wr5 = 1'b0; rd5 = 1'b1;
`ifdef SFIFO_GEN_FWFT_EN
        check(tag, {24'd0, rdata5}, {24'd0, exp});
        step();
`else
        step();
        check(tag, {24'd0, rdata5}, {24'd0, exp});
`endif
        rd5 = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        res = 1'b1;
        wr16 = 1'b0; rd16 = 1'b0; wd16 = 8'h00;
        wr5 = 1'b0; rd5 = 1'b0; wd5 = 8'h00;
        step(); step();

        check("rst_level", {27'd0, level16}, 32'd0);
        check("rst_empty", {31'd0, empty16}, 32'd1);
        check("rst_ae", {31'd0, ae16}, 32'd1);
        check("rst_full", {31'd0, full16}, 32'd0);
        check("rst_af", {31'd0, af16}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid16}, 32'd0);
        check("rst_ovf", {31'd0, ovf16}, 32'd0);
        check("rst_unf", {31'd0, unf16}, 32'd0);
        check("rst_level5", {29'd0, level5}, 32'd0);
`ifndef SFIFO_GEN_FWFT_EN
        check("rst_rdata", {24'd0, rdata16}, 32'd0);
`endif
        res = 1'b0;
        step();

        // Fill 0x01..0x10, then a 17th write is rejected.
        for (int i = 1; i <= 16; i++) begin
            push16(8'(i));
            check($sformatf("fill_level_%0d", i), {27'd0, level16}, 32'(i));
            check($sformatf("fill_af_%0d", i), {31'd0, af16}, {31'd0, (i >= 14)});
            check($sformatf("fill_full_%0d", i), {31'd0, full16}, {31'd0, (i == 16)});
            check($sformatf("fill_ovf_%0d", i), {31'd0, ovf16}, 32'd0);
        end
        push16(8'h11);
        check("ovf_pulse", {31'd0, ovf16}, 32'd1);
        check("ovf_level", {27'd0, level16}, 32'd16);
        check("ovf_full", {31'd0, full16}, 32'd1);
        step();
        check("ovf_single", {31'd0, ovf16}, 32'd0);

        // Drain 16 words in order, then a 17th read underflows.
        for (int i = 1; i <= 16; i++) begin
            pop16($sformatf("drain_%0d", i), 8'(i));
            check($sformatf("drain_level_%0d", i), {27'd0, level16}, 32'(16 - i));
            check($sformatf("drain_ae_%0d", i), {31'd0, ae16}, {31'd0, ((16 - i) <= 2)});
        end
        check("drain_empty", {31'd0, empty16}, 32'd1);
        rd16 = 1'b1;
        step();
        rd16 = 1'b0;
        check("unf_pulse", {31'd0, unf16}, 32'd1);
        check("unf_level", {27'd0, level16}, 32'd0);
        check("unf_empty", {31'd0, empty16}, 32'd1);
        check("unf_rvalid", {31'd0, rvalid16}, 32'd0);
        step();
        check("unf_single", {31'd0, unf16}, 32'd0);

        // Simultaneous read and write at full.
        for (int i = 0; i < 16; i++) push16(8'(8'h20 + i));
        check("sim_full_pre", {31'd0, full16}, 32'd1);
        wr16 = 1'b1; rd16 = 1'b1; wd16 = 8'hAA;
`ifdef SFIFO_GEN_FWFT_EN
        check("sim_full_rdata", {24'd0, rdata16}, 32'h20);
        step();
`else
        step();
        check("sim_full_rdata", {24'd0, rdata16}, 32'h20);
`endif
        wr16 = 1'b0; rd16 = 1'b0;
        check("sim_full_level", {27'd0, level16}, 32'd16);
        check("sim_full_ovf", {31'd0, ovf16}, 32'd0);
        check("sim_full_full", {31'd0, full16}, 32'd1);
        for (int i = 1; i < 16; i++) pop16($sformatf("sim_full_pop_%0d", i), 8'(8'h20 + i));
        pop16("sim_full_last", 8'hAA);
        check("sim_full_empty", {31'd0, empty16}, 32'd1);

        // Simultaneous read and write at empty.
        wr16 = 1'b1; rd16 = 1'b1; wd16 = 8'h55;
        step();
        wr16 = 1'b0; rd16 = 1'b0;
        check("sim_empty_unf", {31'd0, unf16}, 32'd1);
        check("sim_empty_level", {27'd0, level16}, 32'd1);
        check("sim_empty_empty", {31'd0, empty16}, 32'd0);
`ifdef SFIFO_GEN_FWFT_EN
        check("sim_empty_rvalid", {31'd0, rvalid16}, 32'd1);
`else
        check("sim_empty_rvalid", {31'd0, rvalid16}, 32'd0);
`endif
        step();
        check("sim_empty_unf_off", {31'd0, unf16}, 32'd0);
        pop16("sim_empty_pop", 8'h55);

        // Reset mid-operation, asserted between edges.
        for (int i = 0; i < 7; i++) push16(8'(8'h30 + i));
        pop16("pre_rst_pop", 8'h30);
        check("pre_rst_level", {27'd0, level16}, 32'd6);
        #2;
        res = 1'b1;
        #1;
        check("mid_rst_level", {27'd0, level16}, 32'd0);
        check("mid_rst_empty", {31'd0, empty16}, 32'd1);
        check("mid_rst_rvalid", {31'd0, rvalid16}, 32'd0);
`ifndef SFIFO_GEN_FWFT_EN
        check("mid_rst_rdata", {24'd0, rdata16}, 32'd0);
`endif
        res = 1'b0;
        step();
        push16(8'h77);
        check("post_rst_level", {27'd0, level16}, 32'd1);
        pop16("post_rst_pop", 8'h77);
        check("post_rst_empty", {31'd0, empty16}, 32'd1);

        // DEPTH=5 wrap: 4 rounds of 3 writes and 3 reads, data 0..11.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 3; k++) begin
                wr5 = 1'b1; wd5 = 8'(r * 3 + k);
                step();
                wr5 = 1'b0;
                check($sformatf("wrap_wlevel_%0d_%0d", r, k), {29'd0, level5}, 32'(k + 1));
            end
            for (int k = 0; k < 3; k++) begin
                pop5($sformatf("wrap_data_%0d_%0d", r, k), 8'(r * 3 + k));
                check($sformatf("wrap_rlevel_%0d_%0d", r, k), {29'd0, level5}, 32'(2 - k));
            end
        end
        check("wrap_empty", {31'd0, empty5}, 32'd1);
        check("wrap_ovf", {31'd0, ovf5}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
